float_rounder: RTL

FLOAT_ROUNDER -- requirements
Module: float_rounder

---
 rtl/float_rounder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/float_rounder.sv
// IEEE-754 single-precision rounder/packer: 2-stage pipeline (S1 denormalize, S2 round/pack).
// Define FPU_SUBNORMAL_EN for gradual underflow; otherwise tiny results flush to signed zero.
module float_rounder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        valid_out,
  input  logic        ready_in,
  input  logic [23:0] man_in,
  input  logic [9:0]  exp_in,
  input  logic        sgn_in,
  input  logic        round_bit,
  input  logic        sticky_bit,
  input  logic        IV,
  input  logic        DZ,
  input  logic [2:0]  rm,
  input  logic        skip_round,
  output logic [31:0] float_out,
  output logic [4:0]  fflags
);

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // a producer keeps valid and data steady until that edge, and ready never waits on valid.
  logic        s1_valid_q;
  logic [23:0] s1_man_q;
  logic [9:0]  s1_exp_q;
  logic        s1_sgn_q;
  logic        s1_round_q;
  logic        s1_sticky_q;
  logic        s1_tiny_q;
  logic        s1_skip_q;
  logic        s1_iv_q;
  logic        s1_dz_q;
  logic [2:0]  s1_rm_q;

  logic        s2_valid_q;
  logic [31:0] float_q;
  logic [4:0]  fflags_q;

  logic        s2_ready;
  logic        accept;

  logic        tiny_d;
  logic [23:0] s1_man_d;
  logic [9:0]  s1_exp_d;
  logic        s1_round_d;
  logic        s1_sticky_d;

  logic        inexact;
  logic        inc;
  logic [24:0] sum;
  logic [22:0] frac;
  logic [10:0] exp_r;
  logic        overflow;
  logic        ovf_to_inf;
  logic [31:0] float_d;
  logic [4:0]  fflags_d;

  assign s2_ready  = !s2_valid_q || ready_in;
  assign ready_out = reset_n && (!s1_valid_q || s2_ready);
  assign accept    = valid_in && ready_out;
  assign valid_out = s2_valid_q;
  assign float_out = float_q;
  assign fflags    = fflags_q;

`ifdef FPU_SUBNORMAL_EN
  logic [10:0] shift_raw;
  logic [4:0]  shift_amt;
  logic [49:0] shifted;

  // Shift of 1 - exp, saturated at 26 where every mantissa bit has reached sticky.
  always_comb begin
    shift_raw = 11'd1 - {exp_in[9], exp_in};
    shift_amt = (shift_raw > 11'd26) ? 5'd26 : shift_raw[4:0];
    shifted   = {man_in, round_bit, 25'd0} >> shift_amt;
  end
`endif

  // S1: tiny detection on the raw exponent, then optional denormalization.
  always_comb begin
    tiny_d      = exp_in[9] || (exp_in == 10'd0);
    s1_man_d    = man_in;
    s1_exp_d    = exp_in;
    s1_round_d  = round_bit;
    s1_sticky_d = sticky_bit;
`ifdef FPU_SUBNORMAL_EN
    if (tiny_d && !skip_round) begin
      s1_man_d    = shifted[49:26];
      s1_round_d  = shifted[25];
      s1_sticky_d = sticky_bit || (|shifted[24:0]);
      s1_exp_d    = 10'd0;
    end
`endif
  end

  // S2: rounding increment selection.
  always_comb begin
    inexact = s1_round_q || s1_sticky_q;
    case (s1_rm_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_sgn_q && inexact;
      RM_RUP:  inc = !s1_sgn_q && inexact;
      RM_RMM:  inc = s1_round_q;
      default: inc = s1_round_q && (s1_sticky_q || s1_man_q[0]);
    endcase
  end

  // S2: add, renormalize on carry-out, promote a subnormal that rounds into bit 23.
  always_comb begin
    sum = {1'b0, s1_man_q} + {24'd0, inc};
    if (sum[24]) begin
      frac  = sum[23:1];
      exp_r = {1'b0, s1_exp_q} + 11'd1;
    end else begin
      frac  = sum[22:0];
      exp_r = ((s1_exp_q == 10'd0) && sum[23]) ? 11'd1 : {1'b0, s1_exp_q};
    end
    overflow = (exp_r >= 11'd255);
    case (s1_rm_q)
      RM_RTZ:  ovf_to_inf = 1'b0;
      RM_RDN:  ovf_to_inf = s1_sgn_q;
      RM_RUP:  ovf_to_inf = !s1_sgn_q;
      default: ovf_to_inf = 1'b1;
    endcase
  end

  // S2: result and flag selection, fflags = {NV, DZ, OF, UF, NX}.
  always_comb begin
    float_d  = {s1_sgn_q, exp_r[7:0], frac};
    fflags_d = {s1_iv_q, s1_dz_q, 1'b0, s1_tiny_q && inexact, inexact};
    if (s1_skip_q) begin
      float_d  = {s1_sgn_q, s1_exp_q[7:0], s1_man_q[22:0]};
      fflags_d = {s1_iv_q, s1_dz_q, 3'b000};
    end
`ifndef FPU_SUBNORMAL_EN
    else if (s1_tiny_q) begin
      float_d  = {s1_sgn_q, 31'd0};
      fflags_d = {s1_iv_q, s1_dz_q, 3'b011};
    end
`endif
    else if (overflow) begin
      float_d  = ovf_to_inf ? {s1_sgn_q, 8'hFF, 23'd0} : {s1_sgn_q, 8'hFE, 23'h7FFFFF};
      fflags_d = {s1_iv_q, s1_dz_q, 1'b1, s1_tiny_q, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_man_q    <= 24'd0;
      s1_exp_q    <= 10'd0;
      s1_sgn_q    <= 1'b0;
      s1_round_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_tiny_q   <= 1'b0;
      s1_skip_q   <= 1'b0;
      s1_iv_q     <= 1'b0;
      s1_dz_q     <= 1'b0;
      s1_rm_q     <= 3'd0;
      s2_valid_q  <= 1'b0;
      float_q     <= 32'd0;
      fflags_q    <= 5'd0;
    end else begin
      if (ready_out) begin
        s1_valid_q <= valid_in;
      end
      if (accept) begin
        s1_man_q    <= s1_man_d;
        s1_exp_q    <= s1_exp_d;
        s1_sgn_q    <= sgn_in;
        s1_round_q  <= s1_round_d;
        s1_sticky_q <= s1_sticky_d;
        s1_tiny_q   <= tiny_d;
        s1_skip_q   <= skip_round;
        s1_iv_q     <= IV;
        s1_dz_q     <= DZ;
        s1_rm_q     <= rm;
      end
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          float_q  <= float_d;
          fflags_q <= fflags_d;
        end
      end
    end
  end

endmodule
